time_keeper_ctrl: RTL and testbench

Wall-clock sequencer driven by the 1 ms tick from the millisecond timebase. It accumulates ms ticks into seconds and maintains the HH:MM:SS time and the HH:MM alarm registers. A button-driven mode FSM handles time and alarm setting, and the block asserts the alarm ring output. It sits between the ms timebase and the display/alarm output logic.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/btn_edge.sv | 21 ++
 rtl/time_keeper_ctrl.sv | 164 ++++++++++++++++
 tb/tb_time_keeper_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared mode encodings, field limits and widths for the wall-clock sequencer.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_HR     = 3'd1,
    SET_MIN    = 3'd2,
    SET_AL_HR  = 3'd3,
    SET_AL_MIN = 3'd4
  } mode_t;

  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_SEC  = 59;

  localparam int unsigned HR_W  = 5;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level; emits a registered one-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end

endmodule

// File: rtl/time_keeper_ctrl.sv
// Wall-clock sequencer: ms ticks -> HH:MM:SS, button-driven set modes, alarm match and ring.
module time_keeper_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned RING_SECS     = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ms_tick,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             alarm_en,
  input  logic             alarm_off,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [HR_W-1:0]  al_hours,
  output logic [MIN_W-1:0] al_minutes,
  output logic [2:0]       mode,
  output logic             sec_tick,
  output logic             alarm_ring
);

  localparam int unsigned MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned RC_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam logic [MS_W-1:0] MS_MAX = MS_W'(TICKS_PER_SEC - 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RING_SECS - 1);

  mode_t             state;
  logic [MS_W-1:0]   ms_cnt;
  logic [RC_W-1:0]   ring_cnt;
  logic              mode_rise;
  logic              inc_rise;
  logic              counting;
  logic              adv;
  logic              match;
  logic [HR_W-1:0]   hr_nx;
  logic [MIN_W-1:0]  min_nx;
  logic [SEC_W-1:0]  sec_nx;

  btn_edge u_mode_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_mode),
    .rise  (mode_rise)
  );

  btn_edge u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_inc),
    .rise  (inc_rise)
  );

  assign mode = state;

  // Next time-of-day after one second, including the full carry chain.
  always_comb begin
    hr_nx  = hours;
    min_nx = minutes;
    sec_nx = seconds + 1'b1;
    if (seconds == SEC_W'(MAX_SEC)) begin
      sec_nx = '0;
      if (minutes == MIN_W'(MAX_MIN)) begin
        min_nx = '0;
        hr_nx  = (hours == HR_W'(MAX_HOUR)) ? '0 : hours + 1'b1;
      end else begin
        min_nx = minutes + 1'b1;
      end
    end
  end

  always_comb begin
    counting = state inside {RUN, SET_AL_HR, SET_AL_MIN};
    adv      = counting && ms_tick && (ms_cnt == MS_MAX);
    match    = adv && (state == RUN) && (sec_nx == '0) &&
               (min_nx == al_minutes) && (hr_nx == al_hours);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      ms_cnt     <= '0;
      ring_cnt   <= '0;
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      al_hours   <= '0;
      al_minutes <= '0;
      sec_tick   <= 1'b0;
      alarm_ring <= 1'b0;
    end else begin
      sec_tick <= 1'b0;

      if (counting && ms_tick) begin
        if (ms_cnt == MS_MAX) begin
          ms_cnt   <= '0;
          sec_tick <= 1'b1;
          hours    <= hr_nx;
          minutes  <= min_nx;
          seconds  <= sec_nx;
        end else begin
          ms_cnt <= ms_cnt + 1'b1;
        end
      end

      if (alarm_off || !alarm_en || mode_rise) begin
        alarm_ring <= 1'b0;
      end else if (match) begin
        alarm_ring <= 1'b1;
        ring_cnt   <= '0;
      end else if (alarm_ring && adv) begin
        if (ring_cnt == RC_MAX) begin
          alarm_ring <= 1'b0;
        end else begin
          ring_cnt <= ring_cnt + 1'b1;
        end
      end

      // Placed after the timebase so entry clears override a coincident advance.
      case (state)
        RUN: begin
          if (mode_rise) begin
            state   <= SET_HR;
            ms_cnt  <= '0;
            seconds <= '0;
          end
        end
        SET_HR: begin
          if (mode_rise) begin
            state <= SET_MIN;
          end else if (inc_rise) begin
            hours <= (hours == HR_W'(MAX_HOUR)) ? '0 : hours + 1'b1;
          end
        end
        SET_MIN: begin
          if (mode_rise) begin
            state  <= SET_AL_HR;
            ms_cnt <= '0;
          end else if (inc_rise) begin
            minutes <= (minutes == MIN_W'(MAX_MIN)) ? '0 : minutes + 1'b1;
          end
        end
        SET_AL_HR: begin
          if (mode_rise) begin
            state <= SET_AL_MIN;
          end else if (inc_rise) begin
            al_hours <= (al_hours == HR_W'(MAX_HOUR)) ? '0 : al_hours + 1'b1;
          end
        end
        SET_AL_MIN: begin
          if (mode_rise) begin
            state <= RUN;
          end else if (inc_rise) begin
            al_minutes <= (al_minutes == MIN_W'(MAX_MIN)) ? '0 : al_minutes + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_time_keeper_ctrl.sv
// Directed bench for time_keeper_ctrl with a scoreboard of expected times on each sec_tick.
module tb_time_keeper_ctrl;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ms_tick;
  logic       btn_mode;
  logic       btn_inc;
  logic       alarm_en;
  logic       alarm_off;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] al_hours;
  logic [5:0] al_minutes;
  logic [2:0] mode;
  logic       sec_tick;
  logic       alarm_ring;

  int n_tests = 0;
  int n_fail  = 0;

  int mh, mm, msx, mcnt, mmode, mah, mam;
  logic [31:0] sb_q[$];

  time_keeper_ctrl #(
    .TICKS_PER_SEC (TPS),
    .RING_SECS     (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ms_tick    (ms_tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .alarm_en   (alarm_en),
    .alarm_off  (alarm_off),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .al_hours   (al_hours),
    .al_minutes (al_minutes),
    .mode       (mode),
    .sec_tick   (sec_tick),
    .alarm_ring (alarm_ring)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tpack(input int h, input int m, input int s);
    return {15'b0, h[4:0], m[5:0], s[5:0]};
  endfunction

  function automatic logic [31:0] fpack(input int h, input int m, input int ah, input int am);
    return {10'b0, h[4:0], m[5:0], ah[4:0], am[5:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; msx = 0; mcnt = 0; mmode = 0; mah = 0; mam = 0;
    sb_q.delete();
  endtask

  task automatic advance();
    msx++;
    if (msx == 60) begin
      msx = 0;
      mm++;
      if (mm == 60) begin
        mm = 0;
        mh = (mh + 1) % 24;
      end
    end
  endtask

  task automatic tick();
    logic adv_e;
    ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
    adv_e = 1'b0;
    if (mmode == 0 || mmode == 3 || mmode == 4) begin
      if (mcnt == TPS - 1) begin
        mcnt = 0;
        adv_e = 1'b1;
        advance();
        sb_q.push_back(tpack(mh, mm, msx));
      end else begin
        mcnt++;
      end
    end
    check("time", tpack(hours, minutes, seconds), tpack(mh, mm, msx));
    check("sec_tick", {31'b0, sec_tick}, {31'b0, adv_e});
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    cyc();
    mmode = (mmode == 4) ? 0 : mmode + 1;
    if (mmode == 1) begin
      msx = 0;
      mcnt = 0;
    end
    if (mmode == 3) mcnt = 0;
    check("mode", {29'b0, mode}, mmode);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    cyc();
    btn_inc = 1'b0;
    cyc();
    case (mmode)
      1: mh  = (mh + 1) % 24;
      2: mm  = (mm + 1) % 60;
      3: mah = (mah + 1) % 24;
      4: mam = (mam + 1) % 60;
      default: ;
    endcase
    check("fields", fpack(hours, minutes, al_hours, al_minutes), fpack(mh, mm, mah, mam));
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) press_inc();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cyc();
    model_reset();
    check({tag, "_time"}, tpack(hours, minutes, seconds), tpack(0, 0, 0));
    check({tag, "_alarm"}, {21'b0, al_hours, al_minutes}, 0);
    check({tag, "_mode"}, {29'b0, mode}, 0);
    check({tag, "_sec_tick"}, {31'b0, sec_tick}, 0);
    check({tag, "_ring"}, {31'b0, alarm_ring}, 0);
    reset = 1'b0;
    cyc();
  endtask

  always @(negedge clk) begin
    if (sec_tick === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_sec_tick", {31'b0, sec_tick}, 0);
      end else begin
        logic [31:0] exp_t;
        exp_t = sb_q.pop_front();
        check("sb_time", tpack(hours, minutes, seconds), exp_t);
      end
    end
  end

  initial begin
    reset = 1'b1; ms_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    alarm_en = 1'b0; alarm_off = 1'b0;
    model_reset();
    cyc();
    do_reset("reset");

    // First second: three ticks hold, fourth advances.
    ticks(4);

    // Hour/minute setting with wrap, time frozen.
    press_mode();
    check("set_hr_sec_clear", {26'b0, seconds}, 0);
    incs(25);
    ticks(5);
    press_mode();
    incs(61);
    ticks(3);

    // Back to SET_HR, then simultaneous mode+inc: mode wins.
    for (int i = 0; i < 4; i++) press_mode();
    btn_mode = 1'b1; btn_inc = 1'b1;
    cyc();
    btn_mode = 1'b0; btn_inc = 1'b0;
    cyc();
    mmode = 2;
    check("simul_mode", {29'b0, mode}, 2);
    check("simul_hours", {27'b0, hours}, mh);

    // Held inc: exactly one increment.
    btn_inc = 1'b1;
    repeat (10) cyc();
    btn_inc = 1'b0;
    cyc();
    mm = (mm + 1) % 60;
    check("held_inc", fpack(hours, minutes, al_hours, al_minutes), fpack(mh, mm, mah, mam));

    // Set 23:59:00, run to 23:59:58, then wrap to 00:00:00.
    for (int i = 0; i < 4; i++) press_mode();
    incs(22);
    press_mode();
    incs(57);
    for (int i = 0; i < 3; i++) press_mode();
    ticks(58 * TPS);
    ticks(2 * TPS);
    check("day_wrap", tpack(hours, minutes, seconds), tpack(0, 0, 0));
    check("no_ring_disabled", {31'b0, alarm_ring}, 0);

    // Alarm 00:01, ring for RING_SECS seconds.
    for (int i = 0; i < 4; i++) press_mode();
    press_inc();
    press_mode();
    alarm_en = 1'b1;
    ticks(59 * TPS);
    check("ring_before", {31'b0, alarm_ring}, 0);
    ticks(TPS);
    check("ring_match", {31'b0, alarm_ring}, 1);
    ticks(2 * TPS);
    check("ring_hold", {31'b0, alarm_ring}, 1);
    ticks(TPS);
    check("ring_expire", {31'b0, alarm_ring}, 0);

    // Alarm 00:02, cancel with alarm_off.
    for (int i = 0; i < 4; i++) press_mode();
    press_inc();
    press_mode();
    ticks(59 * TPS);
    ticks(TPS);
    check("ring_match2", {31'b0, alarm_ring}, 1);
    alarm_off = 1'b1;
    cyc();
    alarm_off = 1'b0;
    check("ring_off", {31'b0, alarm_ring}, 0);

    // Reset in the middle of SET_MIN with edited fields.
    press_mode();
    press_mode();
    press_inc();
    do_reset("reset_setmin");

    // Reset while ringing.
    for (int i = 0; i < 4; i++) press_mode();
    press_inc();
    press_mode();
    ticks(60 * TPS);
    check("ring_match3", {31'b0, alarm_ring}, 1);
    do_reset("reset_ring");

    cyc();
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
